// File: rtl/fourbit_bitset_arbiter_if.sv
// Bus bundle for fourbit_bitset_arbiter. Carries two single-bit set/clear
// requesters, the fill control, and the register contents. The requesters
// and the fill agent sit on the master side; the arbiter is the slave.
interface fourbit_bitset_arbiter_if;
    logic       req0;
    logic [1:0] index0;
    logic       value0;
    logic       ack0;
    logic       req1;
    logic [1:0] index1;
    logic       value1;
    logic       ack1;
    logic       fill_req;
    logic       fill_value;
    logic       fill_busy;
    logic       fill_done;
    logic [3:0] y;

    modport master (
        output req0, index0, value0, req1, index1, value1, fill_req, fill_value,
        input  ack0, ack1, fill_busy, fill_done, y
    );

    modport slave (
        input  req0, index0, value0, req1, index1, value1, fill_req, fill_value,
        output ack0, ack1, fill_busy, fill_done, y
    );
endinterface

// File: rtl/fourbit_bitset_arbiter.sv
// fourbit_bitset_arbiter: owns a 4-bit register. It shares a one-bit-per-cycle
// write datapath between two requesters, using round-robin arbitration, and
// a 4-cycle fill sequencer.
// Optional macro FOURBIT_BITSET_ARB_FIXED_PRIO_EN: when defined, req0 always
// beats req1 and the round-robin pointer is not built.
module fourbit_bitset_arbiter #(
    parameter logic [3:0] RESET_VALUE = 4'b0000
) (
    input  logic                          clk,
    input  logic                          reset,
    fourbit_bitset_arbiter_if.slave       bus
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       fill_val_q, fill_val_d;
    logic [3:0] y_q, y_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
`ifndef FOURBIT_BITSET_ARB_FIXED_PRIO_EN
    logic       rr_q, rr_d;
`endif

    logic       elig0, elig1;
    logic       grant0, grant1;
    logic       wr_en;
    logic [1:0] sel_index;
    logic       sel_value;

    // Eligibility: a requester whose ack is high this cycle has just been
    // served and is still holding the old command, so it sits out one cycle.
    always_comb begin
        elig0 = bus.req0 & ~ack0_q;
        elig1 = bus.req1 & ~ack1_q;
`ifdef FOURBIT_BITSET_ARB_FIXED_PRIO_EN
        grant0 = elig0;
        grant1 = elig1 & ~elig0;
`else
        grant1 = elig1 & (~elig0 | rr_q);
        grant0 = elig0 & ~grant1;
`endif
    end

    // Control: IDLE arbitrates (fill first, then requesters). FILL walks the counter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_val_d = fill_val_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifndef FOURBIT_BITSET_ARB_FIXED_PRIO_EN
        rr_d       = rr_q;
`endif
        wr_en      = 1'b0;
        sel_index  = cnt_q;
        sel_value  = fill_val_q;
        case (state_q)
            IDLE: begin
                if (bus.fill_req) begin
                    fill_val_d = bus.fill_value;
                    state_d    = FILL;
                    cnt_d      = 2'd0;
                    busy_d     = 1'b1;
                end else if (grant0) begin
                    wr_en     = 1'b1;
                    sel_index = bus.index0;
                    sel_value = bus.value0;
                    ack0_d    = 1'b1;
`ifndef FOURBIT_BITSET_ARB_FIXED_PRIO_EN
                    rr_d      = 1'b1;
`endif
                end else if (grant1) begin
                    wr_en     = 1'b1;
                    sel_index = bus.index1;
                    sel_value = bus.value1;
                    ack1_d    = 1'b1;
`ifndef FOURBIT_BITSET_ARB_FIXED_PRIO_EN
                    rr_d      = 1'b0;
`endif
                end
            end
            FILL: begin
                wr_en = 1'b1;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shared datapath: replace exactly one bit of y when a write is selected.
    always_comb begin
        y_d = y_q;
        if (wr_en) y_d[sel_index] = sel_value;
    end

    // State and registered outputs; reset overrides everything, including mid-fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            fill_val_q <= 1'b0;
            y_q        <= RESET_VALUE;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifndef FOURBIT_BITSET_ARB_FIXED_PRIO_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_val_q <= fill_val_d;
            y_q        <= y_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifndef FOURBIT_BITSET_ARB_FIXED_PRIO_EN
            rr_q       <= rr_d;
`endif
        end
    end

    assign bus.y         = y_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.fill_busy = busy_q;
    assign bus.fill_done = done_q;

endmodule

// File: tb/tb_fourbit_bitset_arbiter.sv
// Self-checking bench for fourbit_bitset_arbiter. Each scenario task builds a
// per-cycle plan of stimulus plus expected outputs. Expected values go to the
// scoreboard when the stimulus is driven. They are popped and compared one
// clock edge later.
module tb_fourbit_bitset_arbiter;

    typedef struct packed {
        logic       rst, r0;
        logic [1:0] i0;
        logic       v0, r1;
        logic [1:0] i1;
        logic       v1, fr, fv;
    } stim_t;

    typedef struct packed {
        logic [3:0] y;
        logic       a0, a1, busy, done;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } step_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    fourbit_bitset_arbiter_if bus();

    fourbit_bitset_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk_s(int rst, int r0, int i0, int v0, int r1, int i1, int v1, int fr, int fv);
        stim_t s;
        s.rst = rst[0]; s.r0 = r0[0]; s.i0 = i0[1:0]; s.v0 = v0[0];
        s.r1 = r1[0]; s.i1 = i1[1:0]; s.v1 = v1[0]; s.fr = fr[0]; s.fv = fv[0];
        return s;
    endfunction

    function automatic exp_t mk_e(int y, int a0, int a1, int busy, int done);
        exp_t e;
        e.y = y[3:0]; e.a0 = a0[0]; e.a1 = a1[0]; e.busy = busy[0]; e.done = done[0];
        return e;
    endfunction

    function automatic exp_t observe();
        return {bus.y, bus.ack0, bus.ack1, bus.fill_busy, bus.fill_done};
    endfunction

    task automatic apply(input stim_t s);
        reset          = s.rst;
        bus.req0       = s.r0;
        bus.index0     = s.i0;
        bus.value0     = s.v0;
        bus.req1       = s.r1;
        bus.index1     = s.i1;
        bus.value1     = s.v1;
        bus.fill_req   = s.fr;
        bus.fill_value = s.fv;
    endtask

    // Reset holds everything at its reset value even with requests/fill asserted.
    task automatic test_reset();
        step_t plan[$];
        step_t p;
        exp_t got, want;
        int n = 0;
        plan.push_back({mk_s(1,1,3,1,0,0,0,0,0), mk_e('b0000,0,0,0,0)});
        plan.push_back({mk_s(1,0,0,0,1,2,1,1,1), mk_e('b0000,0,0,0,0)});
        while (plan.size() > 0) begin
            p = plan.pop_front();
            apply(p.s); sb.push_back(p.e);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset step%0d: got %b want %b (y,ack0,ack1,busy,done)", n, got, want);
            end
            n++;
        end
    endtask

    // Single requester: one write and one ack pulse, then a dead cycle with no rewrite.
    task automatic test_single();
        step_t plan[$];
        step_t p;
        exp_t got, want;
        int n = 0;
        plan.push_back({mk_s(1,0,0,0,0,0,0,0,0), mk_e('b0000,0,0,0,0)});
        plan.push_back({mk_s(0,1,2,1,0,0,0,0,0), mk_e('b0100,1,0,0,0)});
        plan.push_back({mk_s(0,1,2,0,0,0,0,0,0), mk_e('b0100,0,0,0,0)});
        plan.push_back({mk_s(0,0,0,0,0,0,0,0,0), mk_e('b0100,0,0,0,0)});
        while (plan.size() > 0) begin
            p = plan.pop_front();
            apply(p.s); sb.push_back(p.e);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL single step%0d: got %b want %b (y,ack0,ack1,busy,done)", n, got, want);
            end
            n++;
        end
    endtask

    // Round-robin: pointer follows the last grant; same-bit writes, last one wins.
    task automatic test_round_robin();
        step_t plan[$];
        step_t p;
        exp_t got, want;
        int n = 0;
        plan.push_back({mk_s(1,0,0,0,0,0,0,0,0), mk_e('b0000,0,0,0,0)});
        plan.push_back({mk_s(0,1,1,1,1,3,1,0,0), mk_e('b0010,1,0,0,0)});
        plan.push_back({mk_s(0,0,0,0,1,3,1,0,0), mk_e('b1010,0,1,0,0)});
        plan.push_back({mk_s(0,0,0,0,0,0,0,0,0), mk_e('b1010,0,0,0,0)});
        plan.push_back({mk_s(0,1,0,1,1,0,0,0,0), mk_e('b1011,1,0,0,0)});
        plan.push_back({mk_s(0,0,0,0,1,0,0,0,0), mk_e('b1010,0,1,0,0)});
        plan.push_back({mk_s(0,1,2,1,0,0,0,0,0), mk_e('b1110,1,0,0,0)});
        plan.push_back({mk_s(0,0,0,0,0,0,0,0,0), mk_e('b1110,0,0,0,0)});
`ifdef FOURBIT_BITSET_ARB_FIXED_PRIO_EN
        plan.push_back({mk_s(0,1,3,0,1,0,1,0,0), mk_e('b0110,1,0,0,0)});
        plan.push_back({mk_s(0,0,0,0,1,0,1,0,0), mk_e('b0111,0,1,0,0)});
`else
        plan.push_back({mk_s(0,1,3,0,1,0,1,0,0), mk_e('b1111,0,1,0,0)});
        plan.push_back({mk_s(0,1,3,0,0,0,0,0,0), mk_e('b0111,1,0,0,0)});
`endif
        plan.push_back({mk_s(0,0,0,0,0,0,0,0,0), mk_e('b0111,0,0,0,0)});
        while (plan.size() > 0) begin
            p = plan.pop_front();
            apply(p.s); sb.push_back(p.e);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL round_robin step%0d: got %b want %b (y,ack0,ack1,busy,done)", n, got, want);
            end
            n++;
        end
    endtask

    // Fill: value latched at entry, requests and fill_req ignored while busy,
    // and arbitration resumes in the fill_done cycle.
    task automatic test_fill();
        step_t plan[$];
        step_t p;
        exp_t got, want;
        int n = 0;
        plan.push_back({mk_s(1,0,0,0,0,0,0,0,0), mk_e('b0000,0,0,0,0)});
        plan.push_back({mk_s(0,0,0,0,0,0,0,1,1), mk_e('b0000,0,0,1,0)});
        plan.push_back({mk_s(0,0,0,0,0,0,0,0,0), mk_e('b0001,0,0,1,0)});
        plan.push_back({mk_s(0,0,0,0,0,0,0,1,0), mk_e('b0011,0,0,1,0)});
        plan.push_back({mk_s(0,0,0,0,0,0,0,0,0), mk_e('b0111,0,0,1,0)});
        plan.push_back({mk_s(0,0,0,0,0,0,0,0,0), mk_e('b1111,0,0,0,1)});
        plan.push_back({mk_s(0,0,0,0,1,0,1,1,0), mk_e('b1111,0,0,1,0)});
        plan.push_back({mk_s(0,0,0,0,1,0,1,0,1), mk_e('b1110,0,0,1,0)});
        plan.push_back({mk_s(0,0,0,0,1,0,1,0,1), mk_e('b1100,0,0,1,0)});
        plan.push_back({mk_s(0,0,0,0,1,0,1,1,1), mk_e('b1000,0,0,1,0)});
        plan.push_back({mk_s(0,0,0,0,1,0,1,0,0), mk_e('b0000,0,0,0,1)});
        plan.push_back({mk_s(0,0,0,0,1,0,1,0,0), mk_e('b0001,0,1,0,0)});
        plan.push_back({mk_s(0,0,0,0,0,0,0,0,0), mk_e('b0001,0,0,0,0)});
        while (plan.size() > 0) begin
            p = plan.pop_front();
            apply(p.s); sb.push_back(p.e);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL fill step%0d: got %b want %b (y,ack0,ack1,busy,done)", n, got, want);
            end
            n++;
        end
    endtask

    // Reset after two fill writes: back to IDLE with no fill_done; next request served at once.
    task automatic test_reset_mid_fill();
        step_t plan[$];
        step_t p;
        exp_t got, want;
        int n = 0;
        plan.push_back({mk_s(1,0,0,0,0,0,0,0,0), mk_e('b0000,0,0,0,0)});
        plan.push_back({mk_s(0,0,0,0,0,0,0,1,1), mk_e('b0000,0,0,1,0)});
        plan.push_back({mk_s(0,0,0,0,0,0,0,0,0), mk_e('b0001,0,0,1,0)});
        plan.push_back({mk_s(0,0,0,0,0,0,0,0,0), mk_e('b0011,0,0,1,0)});
        plan.push_back({mk_s(1,0,0,0,0,0,0,0,0), mk_e('b0000,0,0,0,0)});
        plan.push_back({mk_s(0,0,0,0,0,0,0,0,0), mk_e('b0000,0,0,0,0)});
        plan.push_back({mk_s(0,1,3,1,0,0,0,0,0), mk_e('b1000,1,0,0,0)});
        plan.push_back({mk_s(0,0,0,0,0,0,0,0,0), mk_e('b1000,0,0,0,0)});
        while (plan.size() > 0) begin
            p = plan.pop_front();
            apply(p.s); sb.push_back(p.e);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid_fill step%0d: got %b want %b (y,ack0,ack1,busy,done)", n, got, want);
            end
            n++;
        end
    endtask

    // Both requesters continuously busy: grants alternate every cycle.
    task automatic test_back_to_back();
        step_t plan[$];
        step_t p;
        exp_t got, want;
        int n = 0;
        plan.push_back({mk_s(1,0,0,0,0,0,0,0,0), mk_e('b0000,0,0,0,0)});
        plan.push_back({mk_s(0,1,0,1,1,2,1,0,0), mk_e('b0001,1,0,0,0)});
        plan.push_back({mk_s(0,1,1,1,1,2,1,0,0), mk_e('b0101,0,1,0,0)});
        plan.push_back({mk_s(0,1,1,1,1,3,1,0,0), mk_e('b0111,1,0,0,0)});
        plan.push_back({mk_s(0,1,0,0,1,3,1,0,0), mk_e('b1111,0,1,0,0)});
        plan.push_back({mk_s(0,1,0,0,0,0,0,0,0), mk_e('b1110,1,0,0,0)});
        plan.push_back({mk_s(0,0,0,0,0,0,0,0,0), mk_e('b1110,0,0,0,0)});
        while (plan.size() > 0) begin
            p = plan.pop_front();
            apply(p.s); sb.push_back(p.e);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back step%0d: got %b want %b (y,ack0,ack1,busy,done)", n, got, want);
            end
            n++;
        end
    endtask

    initial begin
        apply(mk_s(1,0,0,0,0,0,0,0,0));
        test_reset();
        test_single();
        test_round_robin();
        test_fill();
        test_reset_mid_fill();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
